// File: rtl/mem_access.sv
// Load/store stage that runs one request/response transaction on the data
// bus for each legal, aligned load or store. It holds the core with stall
// until the access completes, then returns extended load data for writeback.
//
// state  | meaning
// -------+------------------------------------------------------------
// S_IDLE | no access in flight; launches the bus request for a legal access
// S_REQ  | dbus_req high, waiting for dbus_gnt
// S_WAIT | request accepted, waiting for dbus_rvalid or the timeout
// S_DONE | one-cycle completion; done pulses and the core commits
module mem_access #(
  parameter int TIMEOUT = 256
) (
  input  logic        cpu_clk,
  input  logic        cpu_rst,
  input  logic        mem_en,
  input  logic        mem_we,
  input  logic [2:0]  mem_size,
  input  logic [31:0] alu_c,
  input  logic [31:0] rf_rD2,
  output logic        stall,
  output logic [31:0] rd_data,
  output logic        done,
  output logic        misalign,
  output logic        bus_err,
  output logic        dbus_req,
  output logic        dbus_we,
  output logic [31:0] dbus_addr,
  output logic [3:0]  dbus_wstrb,
  output logic [31:0] dbus_wdata,
  input  logic        dbus_gnt,
  input  logic        dbus_rvalid,
  input  logic [31:0] dbus_rdata
);

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [2:0]    size_q;
  logic [1:0]    off_q;

  logic          illegal;
  logic          unaligned;
  logic          go;
  logic [3:0]    wstrb_nxt;
  logic [31:0]   wdata_nxt;
  logic [7:0]    byte_sel;
  logic [15:0]   half_sel;
  logic [31:0]   load_ext;

  // Decode funct3 legality and natural alignment of the presented access.
  always_comb begin
    illegal   = 1'b0;
    unaligned = 1'b0;
    case (mem_size)
      3'b011, 3'b110, 3'b111: illegal = 1'b1;
      3'b100, 3'b101:         illegal = mem_we;
      default:                illegal = 1'b0;
    endcase
    if (mem_size[1:0] == 2'b01 && alu_c[0])
      unaligned = 1'b1;
    if (mem_size == 3'b010 && alu_c[1:0] != 2'b00)
      unaligned = 1'b1;
  end

  assign misalign = mem_en & (illegal | unaligned);
  assign go       = (state == S_IDLE) & mem_en & ~illegal & ~unaligned;

  // Stall is combinational so the launching IDLE cycle already holds the
  // core; reset masks it so the core is released the moment reset lands.
  assign stall = ~cpu_rst & (go | (state == S_REQ) | (state == S_WAIT));

  // Byte strobes and lane-replicated write data for the presented store.
  always_comb begin
    wstrb_nxt = 4'b0000;
    wdata_nxt = 32'h0;
    if (mem_we) begin
      case (mem_size[1:0])
        2'b00: begin
          wstrb_nxt = 4'b0001 << alu_c[1:0];
          wdata_nxt = {4{rf_rD2[7:0]}};
        end
        2'b01: begin
          wstrb_nxt = 4'b0011 << alu_c[1:0];
          wdata_nxt = {2{rf_rD2[15:0]}};
        end
        default: begin
          wstrb_nxt = 4'b1111;
          wdata_nxt = rf_rD2;
        end
      endcase
    end
  end

  // Select the addressed byte/halfword of the response and extend it.
  always_comb begin
    case (off_q)
      2'd0:    byte_sel = dbus_rdata[7:0];
      2'd1:    byte_sel = dbus_rdata[15:8];
      2'd2:    byte_sel = dbus_rdata[23:16];
      default: byte_sel = dbus_rdata[31:24];
    endcase
    half_sel = off_q[1] ? dbus_rdata[31:16] : dbus_rdata[15:0];
    case (size_q)
      3'b000:  load_ext = {{24{byte_sel[7]}}, byte_sel};
      3'b001:  load_ext = {{16{half_sel[15]}}, half_sel};
      3'b100:  load_ext = {24'h0, byte_sel};
      3'b101:  load_ext = {16'h0, half_sel};
      default: load_ext = dbus_rdata;
    endcase
  end

  // Access sequencer with registered bus outputs, result and pulses.
  always_ff @(posedge cpu_clk or posedge cpu_rst) begin
    if (cpu_rst) begin
      state      <= S_IDLE;
      cnt        <= '0;
      size_q     <= 3'b000;
      off_q      <= 2'b00;
      dbus_req   <= 1'b0;
      dbus_we    <= 1'b0;
      dbus_addr  <= 32'h0;
      dbus_wstrb <= 4'b0000;
      dbus_wdata <= 32'h0;
      rd_data    <= 32'h0;
      done       <= 1'b0;
      bus_err    <= 1'b0;
    end else begin
      done    <= 1'b0;
      bus_err <= 1'b0;
      case (state)
        S_IDLE: begin
          if (go) begin
            dbus_req   <= 1'b1;
            dbus_we    <= mem_we;
            dbus_addr  <= {alu_c[31:2], 2'b00};
            dbus_wstrb <= wstrb_nxt;
            dbus_wdata <= wdata_nxt;
            size_q     <= mem_size;
            off_q      <= alu_c[1:0];
            state      <= S_REQ;
          end
        end
        S_REQ: begin
          if (dbus_gnt) begin
            dbus_req <= 1'b0;
            cnt      <= '0;
            state    <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (dbus_rvalid) begin
            if (!dbus_we)
              rd_data <= load_ext;
            done  <= 1'b1;
            state <= S_DONE;
          end else if (cnt == CNT_LAST) begin
            rd_data <= 32'h0;
            bus_err <= 1'b1;
            done    <= 1'b1;
            state   <= S_DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access.sv
// Directed bench for mem_access: loads, stores, illegal/misaligned accesses,
// grant back-pressure, response timeout and mid-transaction reset.
module tb_mem_access;

  logic        cpu_clk = 1'b0;
  logic        cpu_rst;
  logic        mem_en;
  logic        mem_we;
  logic [2:0]  mem_size;
  logic [31:0] alu_c;
  logic [31:0] rf_rD2;
  logic        stall;
  logic [31:0] rd_data;
  logic        done;
  logic        misalign;
  logic        bus_err;
  logic        dbus_req;
  logic        dbus_we;
  logic [31:0] dbus_addr;
  logic [3:0]  dbus_wstrb;
  logic [31:0] dbus_wdata;
  logic        dbus_gnt;
  logic        dbus_rvalid;
  logic [31:0] dbus_rdata;

  int checks   = 0;
  int failures = 0;

  mem_access #(.TIMEOUT(256)) dut (
    .cpu_clk    (cpu_clk),
    .cpu_rst    (cpu_rst),
    .mem_en     (mem_en),
    .mem_we     (mem_we),
    .mem_size   (mem_size),
    .alu_c      (alu_c),
    .rf_rD2     (rf_rD2),
    .stall      (stall),
    .rd_data    (rd_data),
    .done       (done),
    .misalign   (misalign),
    .bus_err    (bus_err),
    .dbus_req   (dbus_req),
    .dbus_we    (dbus_we),
    .dbus_addr  (dbus_addr),
    .dbus_wstrb (dbus_wstrb),
    .dbus_wdata (dbus_wdata),
    .dbus_gnt   (dbus_gnt),
    .dbus_rvalid(dbus_rvalid),
    .dbus_rdata (dbus_rdata)
  );

  always #5 cpu_clk = ~cpu_clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Runs one legal access; the bus model grants after gnt_wait request
  // cycles and answers rv_wait+1 cycles after the grant.
  task automatic access(input string tag, input logic we, input logic [2:0] size,
                        input logic [31:0] addr, input logic [31:0] wd,
                        input int gnt_wait, input int rv_wait, input logic [31:0] rdata,
                        input logic [31:0] exp_addr, input logic [3:0] exp_strb,
                        input logic [31:0] exp_wdata,
                        output int stall_cnt, output int done_cyc,
                        output logic [31:0] rd, output logic err);
    int  n;
    int  req_seen;
    int  wcnt;
    bit  granted;
    bit  seen;
    @(negedge cpu_clk);
    mem_en      = 1'b1;
    mem_we      = we;
    mem_size    = size;
    alu_c       = addr;
    rf_rD2      = wd;
    dbus_gnt    = 1'b0;
    dbus_rvalid = 1'b0;
    dbus_rdata  = rdata;
    n = 0; req_seen = 0; wcnt = 0; granted = 0; seen = 0;
    stall_cnt = 0; done_cyc = 0; rd = 32'h0; err = 1'b0;
    #1;
    check({tag, " misalign"}, 32'(misalign), 32'd0);
    while (!seen && n < 400) begin
      if (n > 0) begin
        @(negedge cpu_clk);
        if (dbus_gnt) granted = 1;
        dbus_gnt = 1'b0;
        if (granted) begin
          wcnt++;
          dbus_rvalid = (wcnt > rv_wait);
        end else if (dbus_req) begin
          req_seen++;
          check({tag, " addr"}, dbus_addr, exp_addr);
          check({tag, " wstrb"}, 32'(dbus_wstrb), 32'(exp_strb));
          check({tag, " we"}, 32'(dbus_we), 32'(we));
          if (we) check({tag, " wdata"}, dbus_wdata, exp_wdata);
          dbus_gnt = (req_seen > gnt_wait);
        end
        #1;
      end
      n++;
      if (stall) stall_cnt++;
      if (done) begin
        seen     = 1;
        done_cyc = n;
        rd       = rd_data;
        err      = bus_err;
      end
    end
    if (!seen) check({tag, " done_seen"}, 32'd0, 32'd1);
    mem_en      = 1'b0;
    dbus_gnt    = 1'b0;
    dbus_rvalid = 1'b0;
    @(negedge cpu_clk);
    #1;
    check({tag, " done_pulse"}, 32'(done), 32'd0);
    check({tag, " err_pulse"}, 32'(bus_err), 32'd0);
  endtask

  // Presents an illegal or misaligned access and confirms it never reaches the bus.
  task automatic bad_access(input string tag, input logic we, input logic [2:0] size,
                            input logic [31:0] addr);
    @(negedge cpu_clk);
    mem_en   = 1'b1;
    mem_we   = we;
    mem_size = size;
    alu_c    = addr;
    rf_rD2   = 32'h5555AAAA;
    #1;
    check({tag, " misalign"}, 32'(misalign), 32'd1);
    for (int i = 0; i < 3; i++) begin
      check({tag, " stall"}, 32'(stall), 32'd0);
      check({tag, " req"}, 32'(dbus_req), 32'd0);
      @(negedge cpu_clk);
      #1;
    end
    mem_en = 1'b0;
  endtask

  int          sc;
  int          dc;
  logic [31:0] rd;
  logic        er;

  initial begin
    cpu_rst     = 1'b1;
    mem_en      = 1'b0;
    mem_we      = 1'b0;
    mem_size    = 3'b000;
    alu_c       = 32'h0;
    rf_rD2      = 32'h0;
    dbus_gnt    = 1'b0;
    dbus_rvalid = 1'b0;
    dbus_rdata  = 32'h0;

    repeat (2) @(negedge cpu_clk);
    #1;
    check("rst req", 32'(dbus_req), 32'd0);
    check("rst stall", 32'(stall), 32'd0);
    check("rst done", 32'(done), 32'd0);
    check("rst err", 32'(bus_err), 32'd0);
    check("rst rd_data", rd_data, 32'h0);
    check("rst addr", dbus_addr, 32'h0);
    check("rst wstrb", 32'(dbus_wstrb), 32'd0);
    cpu_rst = 1'b0;

    access("lw", 1'b0, 3'b010, 32'h100, 32'h0, 0, 0, 32'hDEADBEEF,
           32'h100, 4'b0000, 32'h0, sc, dc, rd, er);
    check("lw stall_cycles", 32'(sc), 32'd3);
    check("lw done_cycle", 32'(dc), 32'd4);
    check("lw rd", rd, 32'hDEADBEEF);
    check("lw err", 32'(er), 32'd0);

    access("lb", 1'b0, 3'b000, 32'h103, 32'h0, 0, 0, 32'h80FF1234,
           32'h100, 4'b0000, 32'h0, sc, dc, rd, er);
    check("lb rd", rd, 32'hFFFFFF80);
    access("lbu", 1'b0, 3'b100, 32'h103, 32'h0, 0, 0, 32'h80FF1234,
           32'h100, 4'b0000, 32'h0, sc, dc, rd, er);
    check("lbu rd", rd, 32'h00000080);
    access("lh", 1'b0, 3'b001, 32'h102, 32'h0, 0, 0, 32'h80FF1234,
           32'h100, 4'b0000, 32'h0, sc, dc, rd, er);
    check("lh rd", rd, 32'hFFFF80FF);
    access("lh_lo", 1'b0, 3'b001, 32'h100, 32'h0, 0, 0, 32'h80FF1234,
           32'h100, 4'b0000, 32'h0, sc, dc, rd, er);
    check("lh_lo rd", rd, 32'h00001234);
    access("lbu1", 1'b0, 3'b100, 32'h101, 32'h0, 0, 0, 32'h80FF1234,
           32'h100, 4'b0000, 32'h0, sc, dc, rd, er);
    check("lbu1 rd", rd, 32'h00000012);
    access("lhu", 1'b0, 3'b101, 32'h102, 32'h0, 0, 0, 32'h80FF1234,
           32'h100, 4'b0000, 32'h0, sc, dc, rd, er);
    check("lhu rd", rd, 32'h000080FF);

    access("sh", 1'b1, 3'b001, 32'h006, 32'h0000ABCD, 0, 1, 32'h12345678,
           32'h004, 4'b1100, 32'hABCDABCD, sc, dc, rd, er);
    check("sh stall_cycles", 32'(sc), 32'd4);
    check("sh done_cycle", 32'(dc), 32'd5);
    check("sh rd_unchanged", rd, 32'h000080FF);
    access("sb", 1'b1, 3'b000, 32'h001, 32'h11223344, 0, 0, 32'h0,
           32'h000, 4'b0010, 32'h44444444, sc, dc, rd, er);
    check("sb rd_unchanged", rd, 32'h000080FF);
    access("sw", 1'b1, 3'b010, 32'h008, 32'hCAFEF00D, 0, 0, 32'h0,
           32'h008, 4'b1111, 32'hCAFEF00D, sc, dc, rd, er);
    check("sw err", 32'(er), 32'd0);

    bad_access("lw_mis", 1'b0, 3'b010, 32'h101);
    bad_access("lh_mis", 1'b0, 3'b001, 32'h103);
    bad_access("f3_011", 1'b0, 3'b011, 32'h100);
    bad_access("f3_110", 1'b0, 3'b110, 32'h100);
    bad_access("st_bu", 1'b1, 3'b100, 32'h100);
    @(negedge cpu_clk);
    mem_size = 3'b011;
    #1;
    check("noen misalign", 32'(misalign), 32'd0);
    mem_size = 3'b000;

    access("gnt_wait", 1'b0, 3'b010, 32'h200, 32'h0, 5, 0, 32'h0BADF00D,
           32'h200, 4'b0000, 32'h0, sc, dc, rd, er);
    check("gnt_wait stall_cycles", 32'(sc), 32'd8);
    check("gnt_wait rd", rd, 32'h0BADF00D);

    access("tmo", 1'b0, 3'b010, 32'h300, 32'h0, 0, 1000, 32'h77777777,
           32'h300, 4'b0000, 32'h0, sc, dc, rd, er);
    check("tmo stall_cycles", 32'(sc), 32'd258);
    check("tmo done_cycle", 32'(dc), 32'd259);
    check("tmo err", 32'(er), 32'd1);
    check("tmo rd", rd, 32'h0);

    // Reset while the request is outstanding drops dbus_req asynchronously.
    @(negedge cpu_clk);
    mem_en = 1'b1; mem_we = 1'b0; mem_size = 3'b010; alu_c = 32'h400;
    @(negedge cpu_clk);
    #1;
    check("rstreq req_before", 32'(dbus_req), 32'd1);
    cpu_rst = 1'b1;
    #1;
    check("rstreq req_after", 32'(dbus_req), 32'd0);
    check("rstreq stall_after", 32'(stall), 32'd0);
    @(negedge cpu_clk);
    cpu_rst = 1'b0;
    mem_en  = 1'b0;

    // Reset during WAIT, then a late response must not complete anything.
    @(negedge cpu_clk);
    mem_en = 1'b1; mem_we = 1'b0; mem_size = 3'b010; alu_c = 32'h404;
    dbus_rdata = 32'h13579BDF;
    @(negedge cpu_clk);
    dbus_gnt = 1'b1;
    @(negedge cpu_clk);
    dbus_gnt = 1'b0;
    #1;
    check("rstwait stall_before", 32'(stall), 32'd1);
    cpu_rst = 1'b1;
    #1;
    check("rstwait stall_after", 32'(stall), 32'd0);
    check("rstwait req_after", 32'(dbus_req), 32'd0);
    check("rstwait done_after", 32'(done), 32'd0);
    @(negedge cpu_clk);
    cpu_rst     = 1'b0;
    mem_en      = 1'b0;
    dbus_rvalid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge cpu_clk);
      #1;
      check("late_rvalid done", 32'(done), 32'd0);
      check("late_rvalid rd", rd_data, 32'h0);
    end
    dbus_rvalid = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_access.md
Name: mem_access

Overview:
- Load/store stage directly downstream of the execute stage in the single-cycle core.
- Consumes the ALU result (`alu_c`) as the effective address and `rf_rD2` as store data.
- Runs a multi-cycle request/response transaction on the data bus and holds the core with `stall` until the access completes.
- Returns sign- or zero-extended load data for writeback.

Parameters:
- TIMEOUT, 256, maximum cycles spent in WAIT before the access is aborted with `bus_err`.

Ports:
- cpu_clk  in  1  core clock; all state updates on the rising edge
- cpu_rst  in  1  asynchronous, active-high reset
- mem_en  in  1  current instruction is a load/store; held stable by the core while `stall`=1
- mem_we  in  1  1=store, 0=load
- mem_size  in  3  funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU (BU/HU are load-only)
- alu_c  in  32  effective byte address
- rf_rD2  in  32  store data, right-aligned
- stall  out  1  holds PC and register-file write while high
- rd_data  out  32  load result; valid in the cycle `done`=1
- done  out  1  one-cycle pulse at access completion
- misalign  out  1  combinational; access is misaligned or funct3 is illegal
- bus_err  out  1  one-cycle pulse when WAIT times out
- dbus_req  out  1  bus request
- dbus_we  out  1  bus write enable
- dbus_addr  out  32  word-aligned address, `{alu_c[31:2],2'b00}`
- dbus_wstrb  out  4  byte strobes
- dbus_wdata  out  32  lane-replicated write data
- dbus_gnt  in  1  request accepted
- dbus_rvalid  in  1  response valid (load data or store ack)
- dbus_rdata  in  32  response data

Behaviour:
- Reset values: state IDLE, all `dbus_*` outputs 0, `rd_data` 0, `done`/`bus_err`/`stall` 0, timeout counter 0.
- Illegal/misaligned (combinational):
  - funct3 ∈ {011, 110, 111}, or store with funct3 100/101, is illegal.
  - H/HU with `alu_c[0]`=1 is misaligned; W with `alu_c[1:0]`≠00 is misaligned.
  - If `mem_en`=1, `misalign`=1. No bus access is made and `stall`=0.
- IDLE:
  - `mem_en` and legal and aligned: `stall`=1 combinationally. Register `we`, strobes, wdata, addr, size and byte offset into the bus outputs. Next state REQ.
  - Otherwise stay in IDLE, `stall`=0.
- REQ:
  - `dbus_req`=1; address, strobes and data held stable.
  - `dbus_gnt`=1: next state WAIT, and `dbus_req` drops on that edge.
  - `dbus_gnt`=0: stay in REQ with `dbus_req` held.
  - `stall`=1.
- WAIT:
  - `stall`=1 and the counter increments each cycle.
  - `dbus_rvalid`=1: capture the extended `rdata` into `rd_data` (loads only; stores leave `rd_data` unchanged). Next state DONE.
  - Counter reaches TIMEOUT-1 with no `rvalid`: pulse `bus_err`, set `rd_data`=0, next state DONE.
- DONE:
  - `done`=1, `stall`=0, so the core commits and advances PC on this edge.
  - Next state IDLE. The instruction now presented is new; an unchanged repeat is treated as a new access.
- Latency: with `gnt` in REQ and `rvalid` one cycle later, `stall` is high for 3 cycles (IDLE, REQ, WAIT) and `done` is asserted in cycle 4. `rvalid` in the same cycle as `gnt` is not legal bus behaviour and is ignored.
- Store strobes/data:
  - SB: `wstrb`=`4'b0001<<off`, `wdata`={4{rD2[7:0]}}.
  - SH: `wstrb`=`4'b0011<<off`, `wdata`={2{rD2[15:0]}}.
  - SW: `wstrb`=1111, `wdata`=`rD2`.
  - Loads: `wstrb`=0000.
- Load extract: select a byte or halfword by the registered offset; sign-extend B/H, zero-extend BU/HU; W passes through.
- `rvalid` seen in IDLE, REQ or DONE is ignored.
- Reset mid-operation forces IDLE immediately and drops `dbus_req` asynchronously. A late response arriving after reset is ignored.

Test Plan:
- LW at 0x100, `gnt` immediate, `rvalid` next cycle with rdata 0xDEADBEEF -> `dbus_addr` 0x100, `stall` high for 3 cycles, `done` in cycle 4 with `rd_data` 0xDEADBEEF.
- LB at 0x103 with rdata 0x80FF1234 -> `rd_data` 0xFFFFFF80. LBU at the same address -> 0x00000080. LHU at 0x102 -> 0x000080FF.
- SH at 0x006 with `rD2` 0x0000ABCD -> `wstrb` 1100, `wdata` 0xABCDABCD, `dbus_we`=1; ack 2 cycles after `gnt` -> `done`, `rd_data` unchanged.
- LW at 0x101, and funct3 011 -> `misalign`=1, `stall`=0, `dbus_req` never asserted.
- `gnt` withheld for 5 cycles -> `dbus_req` and `addr` stable all 5 cycles. `rvalid` withheld for TIMEOUT cycles -> `bus_err` pulse, `rd_data`=0, `done`.
- Assert `cpu_rst` while in WAIT -> `dbus_req`, `stall` and `done` go 0 immediately. A later `rvalid` produces no `done`.
